// File: rtl/pipe_reg_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_skid_if
// Description : Group handshake, flush and age-reference bundle for pipe_reg_skid.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_reg_skid_if #(
  parameter int N_LANE = 4,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6
);
  logic [N_LANE-1:0]        in_vld;
  logic [N_LANE*DATA_W-1:0] in_data;
  logic [N_LANE*IDX_W-1:0]  in_idx;
  logic                     in_rdy;
  logic [N_LANE-1:0]        out_vld;
  logic [N_LANE*DATA_W-1:0] out_data;
  logic [N_LANE*IDX_W-1:0]  out_idx;
  logic                     out_rdy;
  logic                     flush_all;
  logic                     flush_vld;
  logic [IDX_W-1:0]         flush_idx;
  logic [IDX_W-1:0]         rob_head;

  modport master (
    output in_vld, in_data, in_idx, out_rdy, flush_all, flush_vld, flush_idx, rob_head,
    input  in_rdy, out_vld, out_data, out_idx
  );

  modport slave (
    input  in_vld, in_data, in_idx, out_rdy, flush_all, flush_vld, flush_idx, rob_head,
    output in_rdy, out_vld, out_data, out_idx
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg_skid
// Description : Multi-lane pipeline stage with one-group skid buffer, registered
//               in_rdy, age-based selective squash and full flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_skid #(
  parameter int N_LANE = 4,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pipe_reg_skid_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [N_LANE-1:0]        r_main_vld;
  logic [N_LANE*DATA_W-1:0] r_main_data;
  logic [N_LANE*IDX_W-1:0]  r_main_idx;
  logic [N_LANE-1:0]        r_skid_vld;
  logic [N_LANE*DATA_W-1:0] r_skid_data;
  logic [N_LANE*IDX_W-1:0]  r_skid_idx;

  logic [N_LANE-1:0]        w_main_kill;
  logic [N_LANE-1:0]        w_skid_kill;
  logic [N_LANE-1:0]        w_in_kill;
  logic [IDX_W-1:0]         w_flush_age;
  logic                     w_in_rdy;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic [N_LANE-1:0]        w_main_rem;
  logic [N_LANE-1:0]        w_skid_sq;
  logic [N_LANE-1:0]        w_in_sq;
  logic [N_LANE-1:0]        w_main_vld_nxt;
  logic [N_LANE-1:0]        w_skid_vld_nxt;
  logic                     w_main_ld_skid;
  logic                     w_main_ld_in;
  logic                     w_skid_ld_in;

  // Age relative to the ROB head; modulo arithmetic handles index wrap.
  function automatic logic [IDX_W-1:0] f_age(input logic [IDX_W-1:0] x,
                                             input logic [IDX_W-1:0] head);
    return x - head;
  endfunction

  assign w_flush_age = f_age(bus.flush_idx, bus.rob_head);

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    assign w_main_kill[i] = bus.flush_vld &&
        (f_age(r_main_idx[i*IDX_W +: IDX_W], bus.rob_head) > w_flush_age);
    assign w_skid_kill[i] = bus.flush_vld &&
        (f_age(r_skid_idx[i*IDX_W +: IDX_W], bus.rob_head) > w_flush_age);
    assign w_in_kill[i]   = bus.flush_vld &&
        (f_age(bus.in_idx[i*IDX_W +: IDX_W], bus.rob_head) > w_flush_age);
  end

  assign w_in_rdy   = (r_state != ST_TWO);
  assign w_in_fire  = w_in_rdy && (|bus.in_vld);
  assign w_out_fire = bus.out_rdy && (|r_main_vld);

  // A fired head group is gone regardless of squash; what is left in MAIN is filtered.
  assign w_main_rem = w_out_fire ? '0 : (r_main_vld & ~w_main_kill);
  assign w_skid_sq  = r_skid_vld & ~w_skid_kill;
  assign w_in_sq    = bus.in_vld & ~w_in_kill;

  always_comb begin
    w_main_vld_nxt = w_main_rem;
    w_skid_vld_nxt = w_skid_sq;
    w_main_ld_skid = 1'b0;
    w_main_ld_in   = 1'b0;
    w_skid_ld_in   = 1'b0;
    if (bus.flush_all) begin
      w_main_vld_nxt = '0;
      w_skid_vld_nxt = '0;
    end else begin
      if (!(|w_main_rem) && (|w_skid_sq)) begin
        w_main_vld_nxt = w_skid_sq;
        w_skid_vld_nxt = '0;
        w_main_ld_skid = 1'b1;
      end
      // Accept only happens with SKID empty, so it never collides with the collapse.
      if (w_in_fire && (|w_in_sq)) begin
        if (!(|w_main_vld_nxt)) begin
          w_main_vld_nxt = w_in_sq;
          w_main_ld_in   = 1'b1;
        end else begin
          w_skid_vld_nxt = w_in_sq;
          w_skid_ld_in   = 1'b1;
        end
      end
    end

    if (|w_skid_vld_nxt) begin
      w_state_nxt = ST_TWO;
    end else if (|w_main_vld_nxt) begin
      w_state_nxt = ST_ONE;
    end else begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld  <= '0;
      r_main_data <= '0;
      r_main_idx  <= '0;
      r_skid_vld  <= '0;
      r_skid_data <= '0;
      r_skid_idx  <= '0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      if (w_main_ld_skid) begin
        r_main_data <= r_skid_data;
        r_main_idx  <= r_skid_idx;
      end else if (w_main_ld_in) begin
        r_main_data <= bus.in_data;
        r_main_idx  <= bus.in_idx;
      end
      if (w_skid_ld_in) begin
        r_skid_data <= bus.in_data;
        r_skid_idx  <= bus.in_idx;
      end
    end
  end

  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_vld  = r_main_vld;
  assign bus.out_data = r_main_data;
  assign bus.out_idx  = r_main_idx;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_reg_skid
// Description : Directed and random checks of pipe_reg_skid against a group-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_skid;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_reg_skid_if #(.N_LANE(NL), .DATA_W(DW), .IDX_W(IW)) bus ();

  pipe_reg_skid #(.N_LANE(NL), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NL-1:0]    vld;
    logic [NL*DW-1:0] data;
    logic [NL*IW-1:0] idx;
  } grp_t;

  // Stage contents as an ordered list of surviving groups, oldest first.
  grp_t q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [NL-1:0] survivors(input logic [NL-1:0] v,
                                              input logic [NL*IW-1:0] ix);
    logic [NL-1:0] r;
    logic [IW-1:0] a_f;
    logic [IW-1:0] a_l;
    logic [IW-1:0] lane;
    r = v;
    if (!bus.flush_vld) return r;
    a_f = bus.flush_idx - bus.rob_head;
    for (int i = 0; i < NL; i++) begin
      lane = ix[i*IW +: IW];
      a_l  = lane - bus.rob_head;
      if (a_l > a_f) r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_edge();
    grp_t g;
    grp_t nq[$];
    bit   rdy;
    rdy = (q.size() < 2);
    if (bus.flush_all) begin
      q.delete();
      return;
    end
    if (bus.out_rdy && q.size() > 0) g = q.pop_front();
    foreach (q[i]) begin
      g = q[i];
      g.vld = survivors(g.vld, g.idx);
      if (|g.vld) nq.push_back(g);
    end
    if (rdy && (|bus.in_vld)) begin
      g.vld  = survivors(bus.in_vld, bus.in_idx);
      g.data = bus.in_data;
      g.idx  = bus.in_idx;
      if (|g.vld) nq.push_back(g);
    end
    q = nq;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [NL-1:0]    ev;
    logic [NL*DW-1:0] ed;
    logic [NL*IW-1:0] ei;
    logic [NL*DW-1:0] dm;
    logic [NL*IW-1:0] im;
    ev = '0; ed = '0; ei = '0;
    if (q.size() > 0) begin
      ev = q[0].vld; ed = q[0].data; ei = q[0].idx;
    end
    for (int i = 0; i < NL; i++) begin
      dm[i*DW +: DW] = {DW{ev[i]}};
      im[i*IW +: IW] = {IW{ev[i]}};
    end
    chk("in_rdy",   64'(bus.in_rdy), 64'(q.size() < 2));
    chk("out_vld",  64'(bus.out_vld), 64'(ev));
    chk("out_data", 64'(bus.out_data & dm), 64'(ed & dm));
    chk("out_idx",  64'(bus.out_idx & im), 64'(ei & im));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic [NL-1:0] v, input logic [NL*DW-1:0] d,
                       input logic [NL*IW-1:0] ix);
    bus.in_vld  = v;
    bus.in_data = d;
    bus.in_idx  = ix;
  endtask

  initial begin
    bus.in_vld = '0; bus.in_data = '0; bus.in_idx = '0; bus.out_rdy = 1'b0;
    bus.flush_all = 1'b0; bus.flush_vld = 1'b0; bus.flush_idx = '0; bus.rob_head = '0;

    #12;
    chk("rst_out_vld",  64'(bus.out_vld), 64'd0);
    chk("rst_in_rdy",   64'(bus.in_rdy), 64'd1);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_idx",  64'(bus.out_idx), 64'd0);
    #1 rst = 1'b0;

    // single-lane group, one-cycle latency
    drive(4'b0001, 64'h1234, 24'd5);
    bus.out_rdy = 1'b1;
    step();
    chk("t1_vld",  64'(bus.out_vld), 64'h1);
    chk("t1_data", 64'(bus.out_data[15:0]), 64'h1234);
    chk("t1_idx",  64'(bus.out_idx[5:0]), 64'd5);
    chk("t1_rdy",  64'(bus.in_rdy), 64'd1);
    bus.in_vld = '0;
    step();

    // back-to-back A,B,C under stall
    bus.out_rdy = 1'b0;
    drive(4'b1111, 64'hAAAA_AAAA_AAAA_AAAA, 24'd1);
    step();
    drive(4'b0110, 64'hBBBB_BBBB_BBBB_BBBB, 24'd2);
    step();
    chk("t2_rdy_low", 64'(bus.in_rdy), 64'd0);
    drive(4'b1001, 64'hCCCC_CCCC_CCCC_CCCC, 24'd3);
    step();
    step();
    chk("t2_head_A", 64'(bus.out_data), 64'hAAAA_AAAA_AAAA_AAAA);
    bus.out_rdy = 1'b1;
    step();
    chk("t2_head_B", 64'(bus.out_data[31:16]), 64'hBBBB);
    step();
    bus.in_vld = '0;
    chk("t2_head_C", 64'(bus.out_data[15:0]), 64'hCCCC);
    step();
    step();

    // squash across index wrap
    bus.out_rdy = 1'b0;
    bus.rob_head = 6'd60;
    drive(4'b1111, 64'h0123_4567_89AB_CDEF, {6'd1, 6'd0, 6'd63, 6'd62});
    step();
    bus.in_vld = '0;
    bus.flush_vld = 1'b1;
    bus.flush_idx = 6'd63;
    step();
    chk("t3_vld", 64'(bus.out_vld), 64'b0011);
    bus.flush_vld = 1'b0;
    bus.out_rdy = 1'b1;
    step();

    // flush_all from TWO with a group offered
    bus.out_rdy = 1'b0;
    drive(4'b0011, 64'h1111, 24'd7);
    step();
    drive(4'b1100, 64'h2222, 24'd8);
    step();
    drive(4'b1111, 64'h3333, 24'd9);
    bus.flush_all = 1'b1;
    step();
    chk("t4_vld", 64'(bus.out_vld), 64'd0);
    chk("t4_rdy", 64'(bus.in_rdy), 64'd1);
    bus.flush_all = 1'b0;
    bus.in_vld = '0;
    step();
    chk("t4_vld_after", 64'(bus.out_vld), 64'd0);

    // MAIN squashed, SKID collapses forward
    bus.rob_head = 6'd0;
    drive(4'b1111, 64'h5555_5555_5555_5555, {6'd13, 6'd12, 6'd11, 6'd10});
    step();
    drive(4'b1011, 64'h6666_7777_8888_9999, {6'd5, 6'd4, 6'd3, 6'd2});
    step();
    bus.in_vld = '0;
    bus.flush_vld = 1'b1;
    bus.flush_idx = 6'd5;
    step();
    chk("t5_vld",  64'(bus.out_vld), 64'b1011);
    chk("t5_data", 64'(bus.out_data), 64'h6666_7777_8888_9999);
    chk("t5_rdy",  64'(bus.in_rdy), 64'd1);
    bus.flush_vld = 1'b0;
    bus.out_rdy = 1'b1;
    step();

    // asynchronous reset while in TWO
    bus.out_rdy = 1'b0;
    drive(4'b1111, 64'hDEAD, 24'd20);
    step();
    drive(4'b0001, 64'hBEEF, 24'd21);
    step();
    bus.in_vld = '0;
    #3 rst = 1'b1;
    #1;
    chk("t6_vld", 64'(bus.out_vld), 64'd0);
    chk("t6_rdy", 64'(bus.in_rdy), 64'd1);
    q.delete();
    #1 rst = 1'b0;
    drive(4'b0101, 64'hF00D_0000_CAFE, 24'd30);
    bus.out_rdy = 1'b1;
    step();
    chk("t6_post_vld", 64'(bus.out_vld), 64'b0101);
    bus.in_vld = '0;
    step();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) bus.rob_head = 6'($urandom);
      bus.in_vld  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      bus.in_data = {$urandom, $urandom};
      for (int i = 0; i < NL; i++)
        bus.in_idx[i*IW +: IW] = bus.rob_head + 6'($urandom_range(0, 15));
      bus.out_rdy   = ($urandom_range(0, 3) != 0);
      bus.flush_vld = ($urandom_range(0, 9) == 0);
      bus.flush_idx = bus.rob_head + 6'($urandom_range(0, 15));
      bus.flush_all = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
